// File: rtl/add_compare_monitor_if.sv
// Stimulus, observation and report signals of the add/compare scoreboard.
// ADDCMP_FIRST_CAPTURE_EN adds the first-mismatch capture signals.
interface add_compare_monitor_if #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic             cin;
  logic             obs_valid;
  logic [W-1:0]     obs_sum;
  logic             obs_cout;
  logic             clr_stats;
  logic             match_p;
  logic             mismatch_p;
  logic             underflow_p;
  logic             err_sticky;
  logic [CNT_W-1:0] match_cnt;
  logic [CNT_W-1:0] mism_cnt;
  logic [LW-1:0]    level;
`ifdef ADDCMP_FIRST_CAPTURE_EN
  logic [W:0]       first_exp;
  logic [W:0]       first_obs;
  logic [CNT_W-1:0] first_idx;
  logic             first_vld;
`endif

  modport slave (
    input  in_valid, a, b, cin, obs_valid, obs_sum, obs_cout, clr_stats,
    output in_ready, match_p, mismatch_p, underflow_p, err_sticky,
           match_cnt, mism_cnt, level
`ifdef ADDCMP_FIRST_CAPTURE_EN
    , output first_exp, first_obs, first_idx, first_vld
`endif
  );

  modport master (
    output in_valid, a, b, cin, obs_valid, obs_sum, obs_cout, clr_stats,
    input  in_ready, match_p, mismatch_p, underflow_p, err_sticky,
           match_cnt, mism_cnt, level
`ifdef ADDCMP_FIRST_CAPTURE_EN
    , input first_exp, first_obs, first_idx, first_vld
`endif
  );
endinterface

// File: rtl/add_compare_monitor.sv
// In-order adder scoreboard: queues golden {cout,sum}, compares observed results 1 cycle after obs beat.
// Stimulus stalls via in_ready when full; obs always accepted. ADDCMP_FIRST_CAPTURE_EN adds first-mismatch capture.
module add_compare_monitor #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  add_compare_monitor_if.slave mon
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  logic [W:0]       mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d, mism_cnt_q, mism_cnt_d;
  logic             err_q, err_d;
  logic             match_p_q, mismatch_p_q, underflow_p_q;
  logic             push, pop, underflow, mism;
  logic [W:0]       exp_w, obs_w, head_w;

  assign exp_w     = {1'b0, mon.a} + {1'b0, mon.b} + {{W{1'b0}}, mon.cin};
  assign obs_w     = {mon.obs_cout, mon.obs_sum};
  assign head_w    = mem_q[rptr_q];
  // Both decisions use the occupancy at cycle start: no bypass either way.
  assign push      = mon.in_valid & (level_q != FULL);
  assign pop       = mon.obs_valid & (level_q != '0);
  assign underflow = mon.obs_valid & (level_q == '0);
  assign mism      = (obs_w !== head_w);

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    level_d     = level_q;
    match_cnt_d = match_cnt_q;
    mism_cnt_d  = mism_cnt_q;
    err_d       = err_q;
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    if (mon.clr_stats) begin
      match_cnt_d = '0;
      mism_cnt_d  = '0;
      err_d       = 1'b0;
    end else begin
      if (pop && !mism && match_cnt_q != '1) match_cnt_d = match_cnt_q + CNT_W'(1);
      if (pop &&  mism && mism_cnt_q  != '1) mism_cnt_d  = mism_cnt_q  + CNT_W'(1);
      if ((pop && mism) || underflow) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q        <= '0;
      rptr_q        <= '0;
      level_q       <= '0;
      match_cnt_q   <= '0;
      mism_cnt_q    <= '0;
      err_q         <= 1'b0;
      match_p_q     <= 1'b0;
      mismatch_p_q  <= 1'b0;
      underflow_p_q <= 1'b0;
    end else begin
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      level_q       <= level_d;
      match_cnt_q   <= match_cnt_d;
      mism_cnt_q    <= mism_cnt_d;
      err_q         <= err_d;
      match_p_q     <= pop & ~mism;
      mismatch_p_q  <= pop & mism;
      underflow_p_q <= underflow;
      if (push) mem_q[wptr_q] <= exp_w;
    end
  end

`ifdef ADDCMP_FIRST_CAPTURE_EN
  logic [W:0]       first_exp_q, first_obs_q;
  logic [CNT_W-1:0] first_idx_q;
  logic             first_vld_q;

  always_ff @(posedge clk) begin
    if (!rst_n || mon.clr_stats) begin
      first_exp_q <= '0;
      first_obs_q <= '0;
      first_idx_q <= '0;
      first_vld_q <= 1'b0;
    end else if (pop && mism && !first_vld_q) begin
      first_exp_q <= head_w;
      first_obs_q <= obs_w;
      first_idx_q <= match_cnt_q + mism_cnt_q;
      first_vld_q <= 1'b1;
    end
  end

  assign mon.first_exp = first_exp_q;
  assign mon.first_obs = first_obs_q;
  assign mon.first_idx = first_idx_q;
  assign mon.first_vld = first_vld_q;
`endif

  // Ready is forced high while reset is held so upstream never sees a stall then.
  assign mon.in_ready    = !rst_n || (level_q != FULL);
  assign mon.level       = level_q;
  assign mon.match_p     = match_p_q;
  assign mon.mismatch_p  = mismatch_p_q;
  assign mon.underflow_p = underflow_p_q;
  assign mon.err_sticky  = err_q;
  assign mon.match_cnt   = match_cnt_q;
  assign mon.mism_cnt    = mism_cnt_q;
endmodule

// File: tb/tb_add_compare_monitor.sv
// Directed scoreboard bench for add_compare_monitor (W=8, DEPTH=4, CNT_W=4 so saturation is reachable).
module tb_add_compare_monitor;
  localparam int W = 8, DEPTH = 4, CNT_W = 4;
  localparam logic [2:0] K_M = 3'b001, K_X = 3'b010, K_U = 3'b100;

  typedef struct {
    logic [2:0] kind;
    int         mc;
    int         xc;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_err = 0;
  exp_t sb[$];
  exp_t e;

  add_compare_monitor_if #(.W(W), .DEPTH(DEPTH), .CNT_W(CNT_W)) ifc ();
  add_compare_monitor #(.W(W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .mon  (ifc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: every reported result pops the oldest expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (ifc.match_p || ifc.mismatch_p || ifc.underflow_p)) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", 32'({ifc.underflow_p, ifc.mismatch_p, ifc.match_p}), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("result_kind", 32'({ifc.underflow_p, ifc.mismatch_p, ifc.match_p}), 32'(e.kind));
        chk("match_cnt", 32'(ifc.match_cnt), 32'(e.mc));
        chk("mism_cnt", 32'(ifc.mism_cnt), 32'(e.xc));
        chk("err_sticky", 32'(ifc.err_sticky), 32'(e.err));
      end
    end
  end

  task automatic push(input logic [7:0] av, input logic [7:0] bv, input logic c);
    ifc.in_valid = 1'b1;
    ifc.a        = av;
    ifc.b        = bv;
    ifc.cin      = c;
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
  endtask

  task automatic do_obs(input logic [7:0] s, input logic co, input logic [2:0] k,
                        input int mc, input int xc, input logic er, input logic clr);
    exp_t x;
    x.kind = k; x.mc = mc; x.xc = xc; x.err = er;
    sb.push_back(x);
    ifc.obs_valid = 1'b1;
    ifc.obs_sum   = s;
    ifc.obs_cout  = co;
    ifc.clr_stats = clr;
    @(posedge clk); #1;
    ifc.obs_valid = 1'b0;
    ifc.clr_stats = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    ifc.in_valid = 1'b0; ifc.a = '0; ifc.b = '0; ifc.cin = 1'b0;
    ifc.obs_valid = 1'b0; ifc.obs_sum = '0; ifc.obs_cout = 1'b0; ifc.clr_stats = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(ifc.in_ready), 32'd1);
    chk("rst_level", 32'(ifc.level), 32'd0);
    chk("rst_err", 32'(ifc.err_sticky), 32'd0);
    chk("rst_match_cnt", 32'(ifc.match_cnt), 32'd0);
    rst_n = 1'b1;

    // Basic match, then mismatch on dropped carry.
    push(8'h0F, 8'h01, 1'b0);
    do_obs(8'h10, 1'b0, K_M, 1, 0, 1'b0, 1'b0);
    push(8'hFF, 8'h01, 1'b1);
    do_obs(8'h01, 1'b0, K_X, 1, 1, 1'b1, 1'b0);

    // Fill, hold the fifth beat, pop frees a slot only afterwards.
    push(8'h01, 8'h02, 1'b0);
    push(8'h80, 8'h80, 1'b0);
    push(8'hFF, 8'hFF, 1'b1);
    push(8'h00, 8'h00, 1'b0);
    chk("full_level", 32'(ifc.level), 32'd4);
    chk("full_in_ready", 32'(ifc.in_ready), 32'd0);
    ifc.in_valid = 1'b1; ifc.a = 8'h07; ifc.b = 8'h07; ifc.cin = 1'b0;
    @(posedge clk); #1;
    chk("held_level", 32'(ifc.level), 32'd4);
    do_obs(8'h03, 1'b0, K_M, 2, 1, 1'b1, 1'b0);
    chk("pop_full_level", 32'(ifc.level), 32'd3);
    chk("pop_full_ready", 32'(ifc.in_ready), 32'd1);
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
    chk("refill_level", 32'(ifc.level), 32'd4);
    do_obs(8'h00, 1'b1, K_M, 3, 1, 1'b1, 1'b0);
    do_obs(8'hFF, 1'b1, K_M, 4, 1, 1'b1, 1'b0);
    do_obs(8'h00, 1'b0, K_M, 5, 1, 1'b1, 1'b0);
    do_obs(8'h0E, 1'b0, K_M, 6, 1, 1'b1, 1'b0);
    chk("drained_level", 32'(ifc.level), 32'd0);

    // Underflow with same-cycle push: no bypass.
    ifc.in_valid = 1'b1; ifc.a = 8'h10; ifc.b = 8'h20; ifc.cin = 1'b1;
    do_obs(8'h31, 1'b0, K_U, 6, 1, 1'b1, 1'b0);
    ifc.in_valid = 1'b0;
    chk("uflow_level", 32'(ifc.level), 32'd1);
    do_obs(8'h31, 1'b0, K_M, 7, 1, 1'b1, 1'b0);

    // Simultaneous push and pop keeps level.
    push(8'h01, 8'h01, 1'b0);
    ifc.in_valid = 1'b1; ifc.a = 8'h02; ifc.b = 8'h02; ifc.cin = 1'b0;
    do_obs(8'h02, 1'b0, K_M, 8, 1, 1'b1, 1'b0);
    ifc.in_valid = 1'b0;
    chk("pushpop_level", 32'(ifc.level), 32'd1);
    do_obs(8'h04, 1'b0, K_M, 9, 1, 1'b1, 1'b0);

    // Clear wins over a same-cycle mismatch count, pulse still seen.
    push(8'h05, 8'h05, 1'b0);
    do_obs(8'h0B, 1'b0, K_X, 0, 0, 1'b0, 1'b1);
    chk("clr_err", 32'(ifc.err_sticky), 32'd0);
    push(8'hF0, 8'h0F, 1'b1);
    do_obs(8'h00, 1'b1, K_M, 1, 0, 1'b0, 1'b0);

    // Reset mid-queue overrides in_valid and obs_valid.
    push(8'h01, 8'h00, 1'b0);
    push(8'h02, 8'h00, 1'b0);
    push(8'h03, 8'h00, 1'b0);
    chk("prerst_level", 32'(ifc.level), 32'd3);
    rst_n = 1'b0; ifc.in_valid = 1'b1; ifc.obs_valid = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_in_ready", 32'(ifc.in_ready), 32'd1);
    rst_n = 1'b1; ifc.in_valid = 1'b0; ifc.obs_valid = 1'b0;
    chk("rst_mid_level", 32'(ifc.level), 32'd0);
    chk("rst_mid_err", 32'(ifc.err_sticky), 32'd0);
    chk("rst_mid_cnt", 32'(ifc.match_cnt), 32'd0);
    chk("rst_mid_pulse", 32'(ifc.match_p), 32'd0);
    do_obs(8'h01, 1'b0, K_U, 0, 0, 1'b1, 1'b0);
    ifc.clr_stats = 1'b1;
    @(posedge clk); #1;
    ifc.clr_stats = 1'b0;
    chk("clr_only_err", 32'(ifc.err_sticky), 32'd0);

    // Match counter saturates at 15.
    for (int i = 1; i <= 17; i++) begin
      push(8'(i), 8'h00, 1'b0);
      do_obs(8'(i), 1'b0, K_M, (i > 15) ? 15 : i, 0, 1'b0, 1'b0);
    end

`ifdef ADDCMP_FIRST_CAPTURE_EN
    ifc.clr_stats = 1'b1;
    @(posedge clk); #1;
    ifc.clr_stats = 1'b0;
    push(8'h01, 8'h01, 1'b0);
    do_obs(8'h02, 1'b0, K_M, 1, 0, 1'b0, 1'b0);
    push(8'h02, 8'h01, 1'b0);
    do_obs(8'h03, 1'b0, K_M, 2, 0, 1'b0, 1'b0);
    push(8'hFF, 8'hFF, 1'b0);
    do_obs(8'hFE, 1'b0, K_X, 2, 1, 1'b1, 1'b0);
    chk("first_vld", 32'(ifc.first_vld), 32'd1);
    chk("first_idx", 32'(ifc.first_idx), 32'd2);
    chk("first_exp", 32'(ifc.first_exp), 32'h1FE);
    chk("first_obs", 32'(ifc.first_obs), 32'h0FE);
    push(8'h01, 8'h00, 1'b0);
    do_obs(8'h00, 1'b0, K_X, 2, 2, 1'b1, 1'b0);
    chk("first_idx_held", 32'(ifc.first_idx), 32'd2);
    chk("first_exp_held", 32'(ifc.first_exp), 32'h1FE);
    ifc.clr_stats = 1'b1;
    @(posedge clk); #1;
    ifc.clr_stats = 1'b0;
    chk("first_vld_clr", 32'(ifc.first_vld), 32'd0);
    chk("first_exp_clr", 32'(ifc.first_exp), 32'd0);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
